// File: rtl/spi_slave.sv
// spi_slave -- SPI mode-0 (CPOL=0, CPHA=0), MSB-first responder.
//
// SCLK, SS_N and MOSI are oversampled in the clk domain. Each one passes
// through SYNC_STAGES flops. Edges are found by comparing the last stage
// with one further registered copy.
//
// Ports:
//   clk, sreset      system clock; synchronous active-high reset
//   SCLK, SS_N, MOSI asynchronous SPI inputs from the master
//   MISO             slave-out data (0 outside ACTIVE)
//   tx_data/tx_load  word for the next frame; captured only while tx_ready=1
//   tx_ready         high in IDLE
//   rx_data          last received word, right-aligned
//   rx_nbits         SCLK rising edges in the last frame, saturating at SPI_MAXLEN
//   rx_valid         one-cycle pulse, aligned with updated rx_data/rx_nbits
//
// Optional feature (macro SPI_SLAVE_OVERRUN_EN):
//   rx_ack           acknowledges the last delivered word
//   rx_overrun       sticky flag; set when a word is delivered while the
//                    previous one is still unacknowledged
module spi_slave #(
  parameter int SPI_MAXLEN  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          sreset,
  input  logic                          SCLK,
  input  logic                          SS_N,
  input  logic                          MOSI,
  output logic                          MISO,
  input  logic [SPI_MAXLEN-1:0]         tx_data,
  input  logic                          tx_load,
  output logic                          tx_ready,
  output logic [SPI_MAXLEN-1:0]         rx_data,
  output logic [$clog2(SPI_MAXLEN):0]   rx_nbits,
`ifdef SPI_SLAVE_OVERRUN_EN
  input  logic                          rx_ack,
  output logic                          rx_overrun,
`endif
  output logic                          rx_valid
);

  localparam int CW = $clog2(SPI_MAXLEN) + 1;
  localparam int FW = $clog2(SYNC_STAGES + 1);

  typedef enum logic [1:0] {WAIT_IDLE, IDLE, ACTIVE, DONE} state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
  logic                   sclk_d, ss_d;
  logic                   sclk_s, ss_s, mosi_s;
  logic                   sclk_rise, sclk_fall, ss_rise, ss_fall;

  logic [SPI_MAXLEN-1:0]  tx_buf, tx_shift, rx_shift;
  logic [CW-1:0]          cnt;
  logic [FW-1:0]          flush;

  // Synchronizers and edge-detect copies.
  always_ff @(posedge clk) begin
    if (sreset) begin
      sclk_sync <= '0;
      ss_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      ss_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS_N};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      sclk_d    <= sclk_s;
      ss_d      <= ss_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign ss_s      = ss_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise =  sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s &  sclk_d;
  assign ss_rise   =  ss_s   & ~ss_d;
  assign ss_fall   = ~ss_s   &  ss_d;

  // The SS_N synchronizer resets to 1. It still holds that reset value until
  // SYNC_STAGES real samples have replaced it. WAIT_IDLE waits for that flush,
  // so a reset in the middle of a frame does not look like an idle bus.
  always_ff @(posedge clk) begin
    if (sreset)
      flush <= '0;
    else if (state_q == WAIT_IDLE && flush != FW'(SYNC_STAGES))
      flush <= flush + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (sreset) state_q <= WAIT_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_IDLE: if (flush == FW'(SYNC_STAGES) && ss_s) state_d = IDLE;
      IDLE:      if (ss_fall) state_d = ACTIVE;
      ACTIVE:    if (ss_rise) state_d = DONE;
      DONE:      state_d = IDLE;
      default:   state_d = WAIT_IDLE;
    endcase
  end

  assign tx_ready = (state_q == IDLE);
  assign MISO     = (state_q == ACTIVE) & tx_shift[SPI_MAXLEN-1];

  always_ff @(posedge clk) begin
    if (sreset) begin
      tx_buf   <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      cnt      <= '0;
      rx_data  <= '0;
      rx_nbits <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (state_q)
        IDLE: begin
          if (tx_load) tx_buf <= tx_data;
          if (ss_fall) begin
            // A load in the same cycle as frame start goes straight into the frame.
            tx_shift <= tx_load ? tx_data : tx_buf;
            rx_shift <= '0;
            cnt      <= '0;
          end
        end
        ACTIVE: begin
          // A SCLK edge seen together with the SS_N rise is still taken.
          if (sclk_rise) begin
            rx_shift <= {rx_shift[SPI_MAXLEN-2:0], mosi_s};
            if (cnt != CW'(SPI_MAXLEN)) cnt <= cnt + 1'b1;
          end
          if (sclk_fall) tx_shift <= tx_shift << 1;
        end
        DONE: begin
          if (cnt != '0) begin
            rx_data  <= rx_shift;
            rx_nbits <= cnt;
            rx_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SPI_SLAVE_OVERRUN_EN
  logic pend;

  // pend marks a delivered word that has not been acknowledged yet.
  // An ack in the rx_valid cycle or later clears it.
  always_ff @(posedge clk) begin
    if (sreset) begin
      pend       <= 1'b0;
      rx_overrun <= 1'b0;
    end else if (state_q == DONE && cnt != '0) begin
      if (pend) rx_overrun <= 1'b1;
      pend <= 1'b1;
    end else if (rx_ack) begin
      pend <= 1'b0;
    end
  end
`endif

endmodule
